// File: rtl/phy_stream_checker.sv
// Per-channel stream checker: compares each channel against a packed expected vector.
// Optional per-channel mismatch counters (err_cnt) are built when CHECKER_ERRCNT_EN is defined.
module phy_stream_checker #(
  parameter int                                NUM_CH  = 4,
  parameter int                                DATA_W  = 1,
  parameter int                                VEC_LEN = 96,
  parameter logic [NUM_CH*VEC_LEN*DATA_W-1:0]  EXP_VEC = '0,
  parameter int                                REPEAT  = 0
) (
  input  logic                                 clk_ref,
  input  logic                                 reset_N,
  input  logic                                 start,
  input  logic [NUM_CH*DATA_W-1:0]             data_in,
  input  logic [NUM_CH-1:0]                    valid_in,
  output logic [NUM_CH-1:0]                    done,
  output logic [NUM_CH-1:0]                    pass,
  output logic [NUM_CH-1:0]                    fail,
  output logic                                 all_pass,
  output logic [NUM_CH*$clog2(VEC_LEN)-1:0]    first_err_idx
`ifdef CHECKER_ERRCNT_EN
  ,
  output logic [NUM_CH*16-1:0]                 err_cnt
`endif
);

  // state   | meaning
  // S_IDLE  | not armed, beats ignored (after reset)
  // S_CHECK | armed, each valid beat compared against the expected vector
  // S_DONE  | one-shot run finished, beats ignored until the next start
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_t;

  localparam int                IDX_W = $clog2(VEC_LEN);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(VEC_LEN - 1);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [VEC_LEN*DATA_W-1:0] CH_EXP = EXP_VEC[c*VEC_LEN*DATA_W +: VEC_LEN*DATA_W];

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]   r_ferr, w_ferr_nxt;
    logic               r_done, w_done_nxt;
    logic               r_pass, w_pass_nxt;
    logic               r_fail, w_fail_nxt;
    logic [DATA_W-1:0]  w_data, w_exp;
    logic               w_beat, w_mism, w_last;

    assign w_data = data_in[c*DATA_W +: DATA_W];
    assign w_exp  = CH_EXP[r_cnt*DATA_W +: DATA_W];
    assign w_beat = (r_state == S_CHECK) && valid_in[c] && !start;
    assign w_mism = (w_data != w_exp);
    assign w_last = (r_cnt == LAST);

    always_ff @(posedge clk_ref or negedge reset_N) begin
      if (!reset_N) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_ferr  <= '0;
        r_done  <= 1'b0;
        r_pass  <= 1'b0;
        r_fail  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_ferr  <= w_ferr_nxt;
        r_done  <= w_done_nxt;
        r_pass  <= w_pass_nxt;
        r_fail  <= w_fail_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ferr_nxt  = r_ferr;
      w_done_nxt  = r_done;
      w_pass_nxt  = r_pass;
      w_fail_nxt  = r_fail;
      if (start) begin
        w_state_nxt = S_CHECK;
        w_cnt_nxt   = '0;
        w_ferr_nxt  = '0;
        w_done_nxt  = 1'b0;
        w_pass_nxt  = 1'b0;
        w_fail_nxt  = 1'b0;
      end else if (w_beat) begin
        if (w_mism) begin
          w_fail_nxt = 1'b1;
          if (!r_fail) w_ferr_nxt = r_cnt;
        end
        if (REPEAT == 0) begin
          if (w_last) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = !w_fail_nxt;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else begin
          // continuous mode: pass tracks the running result once a lap has completed
          w_cnt_nxt  = w_last ? '0 : r_cnt + 1'b1;
          w_done_nxt = r_done || w_last;
          w_pass_nxt = w_done_nxt && !w_fail_nxt;
        end
      end
    end

`ifdef CHECKER_ERRCNT_EN
    logic [15:0] r_err, w_err_nxt;

    always_comb begin
      w_err_nxt = r_err;
      if (start) w_err_nxt = '0;
      else if (w_beat && w_mism && (r_err != 16'hFFFF)) w_err_nxt = r_err + 16'd1;
    end

    always_ff @(posedge clk_ref or negedge reset_N) begin
      if (!reset_N) r_err <= '0;
      else          r_err <= w_err_nxt;
    end

    assign err_cnt[c*16 +: 16] = r_err;
`endif

    assign done[c]                         = r_done;
    assign pass[c]                         = r_pass;
    assign fail[c]                         = r_fail;
    assign first_err_idx[c*IDX_W +: IDX_W] = r_ferr;
  end

  assign all_pass = &pass;

endmodule
